// File: rtl/psp_pkg.sv
// Shared definitions for the two-requester memory arbiter.
package psp_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // One-hot strobe for a requester index.
  function automatic logic [1:0] grant_onehot(input logic idx);
    logic [1:0] oh;
    if (idx) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone request wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

  // Winner selection from the request pattern and previous grant.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-side and a data-side requester onto a single
// synchronous memory port with one-cycle read latency.
module mem_arbiter
  import psp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  logic              winner_s;
  logic              accept_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              owner_r;
  logic              we_r;
  logic              last_grant_r;
  logic [1:0]        ack_r;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_data_en_r;

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_r),
    .winner     (winner_s)
  );

  // A new transaction is accepted only from IDLE; req elsewhere is ignored.
  always_comb begin
    accept_s = (state_r == IDLE) && (req != 2'b00);
  end

  // Mux the winning requester's command fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = addr0;
    sel_wdata_s = wdata0;
    if (winner_s) begin
      sel_we_s    = we[1];
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we[0];
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Next-state logic: writes skip WAIT, reads spend one cycle there.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT;
        end
      end
      WAIT:    next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Latch the accepted command; the memory address/data registers double as
  // the latched copy, so they hold their value until the next acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r     <= 1'b0;
      we_r        <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      owner_r     <= winner_s;
      we_r        <= sel_we_s;
      mem_addr_r  <= sel_addr_s;
      mem_wdata_r <= sel_wdata_s;
    end
  end

  // Write strobe is high for exactly the ISSUE cycle of a write; the async
  // reset drops it immediately if a write is aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data_en_r <= 1'b0;
    end else begin
      mem_data_en_r <= accept_s & sel_we_s;
    end
  end

  // Capture read data at the end of WAIT; writes leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (state_r == WAIT) begin
      rdata_r <= mem_rdata;
    end
  end

  // Completion strobe is registered so it is high exactly while in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 2'b00;
    end else if (next_state_s == DONE) begin
      ack_r <= grant_onehot(owner_r);
    end else begin
      ack_r <= 2'b00;
    end
  end

  // Round-robin history; reset value lets requester 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (state_r == DONE) begin
      last_grant_r <= owner_r;
    end
  end

  assign ack         = ack_r;
  assign rdata       = rdata_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign mem_data_en = mem_data_en_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req  input  2  per-requester request (bit 0 = instruction side, bit 1 = data side).
REQ-006 SHALL have ports we  input  2  per-requester write enable, meaningful while req high.
REQ-007 SHALL have ports addr0, addr1  input  ADDR_W  per-requester address.
REQ-008 SHALL have ports wdata0, wdata1  input  DATA_W  per-requester write data.
REQ-009 SHALL have port ack  output  2  one-hot completion strobe.
REQ-010 SHALL have port rdata  output  DATA_W  read data, valid while ack high for a read.
REQ-011 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_data_en  output  1 (write enable), mem_rdata  input  DATA_W: one memory port.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-013 IDLE: if any req bit high, SHALL select winner, latch owner, we, addr, wdata into internal registers, go ISSUE; else stay IDLE.
REQ-014 Single request: that requester wins. Both high: requester != last_grant wins (round-robin).
REQ-015 ISSUE: SHALL drive mem_addr/mem_wdata from latched regs, mem_data_en = latched we; next state DONE if write, WAIT if read.
REQ-016 WAIT: memory read latency is one cycle; SHALL capture mem_rdata into rdata register; next state DONE.
REQ-017 DONE: SHALL assert ack[owner] for exactly one cycle, rdata stable; set last_grant = owner; next state IDLE.
REQ-018 mem_data_en SHALL be high only in ISSUE with latched we = 1; mem_addr/mem_wdata hold last value otherwise.
REQ-019 Latency: req sampled in IDLE at edge N; write ack high in cycle N+2, read ack high in cycle N+3.
REQ-020 Transfer completes at edge where req[i] & ack[i]; req[i] still high at the following IDLE is a new transaction.
REQ-021 Requester SHALL NOT observe changes to its addr/we/wdata after acceptance; inputs latched at IDLE edge.
REQ-022 req changes while not IDLE SHALL be ignored until next IDLE.
REQ-023 rdata for write transactions SHALL hold its previous value.
REQ-024 Both requesters continuously requesting SHALL alternate grants 0,1,0,1...

Reset
REQ-025 On rst: state = IDLE, ack = 0, mem_data_en = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, last_grant = 1 (requester 0 wins first tie).
REQ-026 Reset mid-transaction SHALL abort it with no ack; a pending write in ISSUE SHALL have mem_data_en drop immediately (asynchronous).

Structure
REQ-027 ADDR_W/DATA_W defaults and arb_state_t enum (IDLE, ISSUE, WAIT, DONE) SHALL live in shared package psp_pkg.
REQ-028 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req[1:0], last_grant; output winner), purely combinational.

Verification
REQ-029 Single read: req=01, we=00, addr0=0x10, memory[0x10]=0xDEADBEEF -> ack=01 three cycles later, rdata=0xDEADBEEF.
REQ-030 Single write: req=10, we=10, addr1=0x20, wdata1=0x12345678 -> mem_data_en high one cycle with mem_addr=0x20, ack=10 two cycles later; subsequent read of 0x20 returns 0x12345678.
REQ-031 Tie after reset: req=11 held -> grants order 0,1,0,1 over four transactions; no ack both bits.
REQ-032 Input change after accept: addr0 changed 0x10->0x30 in ISSUE -> memory accessed at 0x10 only.
REQ-033 Reset in ISSUE of a write -> mem_data_en falls asynchronously, no ack, memory location unchanged, state IDLE.
REQ-034 Back-to-back: req0 held high across ack -> second transaction starts at next IDLE, no lost or duplicated ack.
